// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
//   Shared FIFO read-side defines for the fifo_rd_stream drain stage.
//   Holds the default FIFO data width, the elastic buffer geometry, the
//   valid/ready handshake macro and the modulo-3 pointer increment helper.
//   No ports.
// -----------------------------------------------------------------------------

`ifndef FIFO_RD_STREAM_HS
`define FIFO_RD_STREAM_HS(valid, ready) ((valid) && (ready))
`endif

package fifo_rd_stream_pkg;

    localparam int FIFO_DATA_WIDTH = 8;

    localparam int BUF_DEPTH = 3;
    localparam int PTR_WIDTH = 2;

    // The buffer is three entries deep, so pointers cannot rely on natural
    // power-of-two rollover; they are wrapped back to zero explicitly.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
//   Bundles the FIFO read port and the outgoing valid/ready stream of the
//   fifo_rd_stream drain stage.
//   master modport : the drain stage (drives fifo_rd_en and the stream)
//   slave modport  : the environment (FIFO read port + stream consumer)
//   Signals: flush, fifo_empty, fifo_rd_en, fifo_rd_data,
//            m_valid, m_ready, m_data, m_last, beat_cnt
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int PKT_LEN    = 16
);

    localparam int CNT_WIDTH = $clog2(PKT_LEN);

    logic                  flush;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [CNT_WIDTH-1:0]  beat_cnt;

    modport master (
        input  flush,
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_last,
        output beat_cnt
    );

    modport slave (
        output flush,
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_last,
        input  beat_cnt
    );

endinterface

// File: rtl/fifo_rd_buf.sv
// -----------------------------------------------------------------------------
// fifo_rd_buf
//   Three-entry synchronous elastic buffer used by fifo_rd_stream.
//   clk, rst   : clock and synchronous active-high reset (clears storage too)
//   clear      : synchronous drop of all entries, storage left untouched
//   push       : write push_data at the tail
//   pop        : retire the head entry
//   count      : number of entries held (0..3)
//   head_data  : data at the head entry
//   not_empty  : at least one entry held
// -----------------------------------------------------------------------------
module fifo_rd_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  not_empty
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  head_ptr;
    logic [PTR_WIDTH-1:0]  tail_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Pops of an empty buffer and pushes into a full one are ignored, so the
    // pointers can never cross even if a caller misbehaves.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'(BUF_DEPTH)) || pop_ok);

    // Storage, pointers and occupancy. Reset also zeroes the storage so the
    // head data reads as zero afterwards; a clear only rewinds the pointers.
    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[tail_ptr] <= push_data;
                tail_ptr      <= ptr_inc(tail_ptr);
            end
            if (pop_ok) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head_ptr];
    assign not_empty = (count != 2'd0);

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side drain stage for async_fifo. Turns the standard-mode FIFO read
//   port (data one cycle after rd_en) into a valid/ready stream through a
//   three-entry elastic buffer and cuts it into PKT_LEN-beat packets.
//   clk  : read-domain clock
//   rst  : synchronous active-high reset
//   bus  : fifo_rd_stream_if.master (flush, FIFO read port, m_* stream,
//          beat_cnt)
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int PKT_LEN    = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_stream_if.master  bus
);

    localparam int                   CNT_WIDTH = $clog2(PKT_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

    logic                  inflight;
    logic [CNT_WIDTH-1:0]  beat_cnt_r;
    logic [1:0]            buf_count;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic [2:0]            credit_used;
    logic                  rd_en;
    logic                  handshake;
    logic                  capture;

    // Credit rule: a read may only be issued when the buffer has room for
    // everything already held plus the word still on its way. Keeping m_ready
    // out of this term is what breaks the ready -> rd_en combinational path.
    assign credit_used = 3'(buf_count) + 3'(inflight);
    assign rd_en       = !rst && !bus.flush && !bus.fifo_empty
                         && (credit_used < 3'(BUF_DEPTH));

    assign handshake = `FIFO_RD_STREAM_HS(buf_valid, bus.m_ready);

    // Data for the read issued last cycle is on fifo_rd_data now; a flush
    // discards it instead of writing it into the buffer.
    assign capture = inflight && !bus.flush;

    fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush),
        .push      (capture),
        .push_data (bus.fifo_rd_data),
        .pop       (handshake),
        .count     (buf_count),
        .head_data (head_data),
        .not_empty (buf_valid)
    );

    // Tracks the outstanding read and the position within the packet.
    // Reset and flush both abandon the outstanding read and restart the
    // packet; otherwise the beat counter only moves on a handshake and
    // wraps after the last beat of the packet.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            inflight   <= 1'b0;
            beat_cnt_r <= '0;
        end else begin
            inflight <= rd_en;
            if (handshake) begin
                beat_cnt_r <= (beat_cnt_r == LAST_BEAT) ? '0 : beat_cnt_r + 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = buf_valid;
    assign bus.m_data     = head_data;
    assign bus.m_last     = buf_valid && (beat_cnt_r == LAST_BEAT);
    assign bus.beat_cnt   = beat_cnt_r;

endmodule
